muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the register file read ports.
- Consumes the two source operands read from the register file and computes MULT/MULTU/DIV/DIVU over multiple cycles.
- Holds the HI/LO result registers read by MFHI/MFLO and written by MTHI/MTLO.
- Exposes busy/done so the pipeline controller can stall dependent instructions.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH each; product/remainder datapath is 2*WIDTH.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- start  input  1  launch request; accepted only when busy=0.
- op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src_a  input  WIDTH  rs operand (multiplicand / dividend).
- src_b  input  WIDTH  rt operand (multiplier / divisor).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when hi/lo receive a new result.
- div_by_zero  output  1  sticky flag for the last DIV/DIVU; valid from done.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset: when rst=0 at a posedge, the following take effect at that edge, regardless of state:
  - state=IDLE;
  - hi=0, lo=0;
  - busy=0, done=0, div_by_zero=0;
  - iteration counter=0.
- Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- States: IDLE, RUN, FIX.
- Operand capture and launch (IDLE, start=1, edge E0):
  - latch op;
  - latch |src_a| and |src_b| (absolute value only for signed ops);
  - latch result-sign bits: quotient/product sign = a[W-1]^b[W-1]; remainder sign = a[W-1];
  - state -> RUN, busy=1 from after E0, counter=0.
- Divide by zero (DIV/DIVU with src_b=0 at E0):
  - state -> FIX directly;
  - the FIX edge (E1) writes hi=src_a (raw, as captured) and lo={WIDTH{1'b1}}, sets div_by_zero=1, and pulses done.
- RUN:
  - one shift-add (multiply) or restoring shift-subtract (divide) step per cycle;
  - counter increments each edge; after the step with counter=WIDTH-1 (edge E_WIDTH), state -> FIX.
- FIX (one cycle):
  - conditionally two's-complement negate the magnitude results per the latched sign bits (signed ops only);
  - write hi/lo; done=1 for exactly the following cycle; busy=0; state -> IDLE.
- Nominal latency: hi/lo/done update at edge E(WIDTH+1), i.e. E33 for WIDTH=32. busy is high from after E0 through the cycle ending at E33.
- Signed corner cases:
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no trap);
  - products always exact in 2*WIDTH bits.
- div_by_zero is cleared at the done edge of any non-zero divide or multiply.
- start while busy=1 is ignored (no queueing); the controller must hold the instruction.
- hi_we/lo_we:
  - applied only when busy=0 and not in FIX;
  - ignored while busy;
  - if asserted in IDLE together with start, the write applies at E0 and is later overwritten by the result;
  - hi_we and lo_we together write both registers with wdata.
- hi/lo are driven directly from registers (no combinational path from inputs).

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state encoding;
  - ITER = WIDTH.
- One sub-module, cond_negate (parameter W): out = neg ? -in : in. Instantiated for operand abs, product fix-up, quotient fix-up, and remainder fix-up.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start at E0 -> at E33: hi=0xFFFFFFFE, lo=0x00000001, done high one cycle, busy low after.
- MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> done at E1, hi=5, lo=0xFFFFFFFF, div_by_zero=1. Following MULTU 2*3 -> div_by_zero=0, lo=6.
- start=1 and hi_we=1 (wdata=0xAA) at E10 mid-MULTU -> both ignored; result unchanged. In IDLE, hi_we with wdata=0x1234 -> hi=0x1234, lo unchanged.
- rst=0 at E15 during DIV -> next cycle busy=0, hi=lo=0, no done pulse. New start after rst=1 completes normally at E0+33.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (MULT, MULTU, DIV, DIVU) as driven on muldiv_unit.op
//   - FSM state encoding (IDLE, RUN, FIX)
//   - ITER: default operand width, which is also the number of RUN steps
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// cond_negate: conditional two's-complement negation.
//   neg : 1 selects -in, 0 passes in through unchanged
//   in  : W-bit value
//   out : W-bit result
module cond_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
//   clk, rst      : clock; synchronous active-low reset
//   start, op     : launch request and operation select (accepted in IDLE only)
//   src_a, src_b  : rs/rt operands
//   hi_we, lo_we  : MTHI/MTLO write enables with data wdata (IDLE only)
//   busy          : operation in progress
//   done          : one-cycle pulse when hi/lo take a new result
//   div_by_zero   : sticky flag describing the last completed operation
//   hi, lo        : result registers
//
// Handshake: start is a level sampled at posedge; it is consumed on the edge
// where the unit is IDLE (busy=0). While busy=1 start is ignored and the
// requester must keep holding it. done pulses for exactly one cycle.
//
// Timing: launch edge E0, WIDTH RUN steps on E1..E_WIDTH, FIX writes hi/lo on
// E(WIDTH+1). A divide by zero jumps straight to FIX and completes on E1.
// The FSM state is held in state_q.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     b_mag_q, b_mag_d;
  // MUL: {partial product, remaining multiplier bits}
  // DIV: {partial remainder, dividend bits / quotient bits}
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 q_sign_q, q_sign_d;
  logic                 r_sign_q, r_sign_d;
  logic                 dbz_pend_q, dbz_pend_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  // Operand magnitudes at launch
  logic             in_signed;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign in_signed = ~op[0];

  cond_negate #(.W(WIDTH)) u_abs_a (
    .neg (in_signed & src_a[WIDTH-1]),
    .in  (src_a),
    .out (a_abs)
  );

  cond_negate #(.W(WIDTH)) u_abs_b (
    .neg (in_signed & src_b[WIDTH-1]),
    .in  (src_b),
    .out (b_abs)
  );

  // Sign fix-up of the magnitude results; unsigned ops never negate.
  logic               q_neg, r_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign q_neg = q_sign_q & ~op_q[0];
  assign r_neg = r_sign_q & ~op_q[0];

  cond_negate #(.W(2*WIDTH)) u_fix_prod (
    .neg (q_neg),
    .in  (acc_q),
    .out (prod_fix)
  );

  cond_negate #(.W(WIDTH)) u_fix_quot (
    .neg (q_neg),
    .in  (acc_q[WIDTH-1:0]),
    .out (quot_fix)
  );

  cond_negate #(.W(WIDTH)) u_fix_rem (
    .neg (r_neg),
    .in  (acc_q[2*WIDTH-1:WIDTH]),
    .out (rem_fix)
  );

  // One shift-add multiply step: add multiplicand into the upper half when
  // the current multiplier LSB is set, then shift the whole pair right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, b_mag_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step: shift the next dividend bit into the
  // remainder and subtract the divisor when it fits. The shifted remainder
  // needs WIDTH+1 bits; the difference always fits WIDTH bits.
  logic [WIDTH:0]     div_rem_sh;
  logic               div_fits;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_fits   = (div_rem_sh >= {1'b0, b_mag_q});
  assign div_diff   = div_rem_sh[WIDTH-1:0] - b_mag_q;
  assign div_next   = div_fits ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                               : {acc_q[2*WIDTH-2:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    b_mag_d    = b_mag_q;
    acc_d      = acc_q;
    q_sign_d   = q_sign_q;
    r_sign_d   = r_sign_q;
    dbz_pend_d = dbz_pend_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d    = op;
          b_mag_d = b_abs;
          cnt_d   = '0;
          busy_d  = 1'b1;
          if (op[1] && (src_b == '0)) begin
            // Divide by zero: FIX passes these through unnegated,
            // giving hi = raw dividend and lo = all ones.
            state_d    = ST_FIX;
            acc_d      = {src_a, {WIDTH{1'b1}}};
            q_sign_d   = 1'b0;
            r_sign_d   = 1'b0;
            dbz_pend_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            acc_d      = {{WIDTH{1'b0}}, a_abs};
            q_sign_d   = in_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            r_sign_d   = in_signed & src_a[WIDTH-1];
            dbz_pend_d = 1'b0;
          end
        end
      end

      ST_RUN: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end

      ST_FIX: begin
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        dbz_d   = dbz_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      b_mag_q    <= '0;
      acc_q      <= '0;
      q_sign_q   <= 1'b0;
      r_sign_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      b_mag_q    <= b_mag_d;
      acc_q      <= acc_d;
      q_sign_q   <= q_sign_d;
      r_sign_q   <= r_sign_d;
      dbz_pend_q <= dbz_pend_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
